// File: rtl/reg_writeback_if.sv
// Execute-to-writeback result handshake bundle.
// The execute stage is the master; the writeback buffer is the slave.
interface reg_writeback_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 3
);
    logic              ex_valid;
    logic              ex_ready;
    logic              ex_wen;
    logic [IDX_W-1:0]  ex_dst_idx;
    logic [DATA_W-1:0] ex_val;

    modport master (
        output ex_valid,
        output ex_wen,
        output ex_dst_idx,
        output ex_val,
        input  ex_ready
    );

    modport slave (
        input  ex_valid,
        input  ex_wen,
        input  ex_dst_idx,
        input  ex_val,
        output ex_ready
    );
endinterface

// File: rtl/reg_writeback.sv
// In-order writeback FIFO feeding the register file write port, with
// per-register busy bits and youngest-match bypass for the read stage.
module reg_writeback #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    reg_writeback_if.slave           ex,
    input  logic                     wb_hold,
    output logic                     rf_we,
    output logic [IDX_W-1:0]         rf_dst_idx,
    output logic [DATA_W-1:0]        rf_w_val,
    output logic [(2**IDX_W)-1:0]    busy,
    input  logic [IDX_W-1:0]         byp_idx1,
    input  logic [IDX_W-1:0]         byp_idx2,
    output logic                     byp_hit1,
    output logic                     byp_hit2,
    output logic [DATA_W-1:0]        byp_val1,
    output logic [DATA_W-1:0]        byp_val2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BUSY_W = 2 ** IDX_W;

    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
    localparam logic [BUSY_W-1:0] BUSY_ONE = BUSY_W'(1);

    logic [IDX_W-1:0]  dst_mem_r [DEPTH];
    logic [DATA_W-1:0] val_mem_r [DEPTH];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;

    logic              ready_s;
    logic              push_s;
    logic              pop_s;

    // Entries indexed by age: age 0 is the head (oldest), age DEPTH-1 the
    // slot that would be the youngest when full.
    logic [PTR_W-1:0]  age_slot_s  [DEPTH];
    logic [DEPTH-1:0]  age_valid_s;

    logic [BUSY_W-1:0] busy_s;
    logic              hit1_s;
    logic              hit2_s;
    logic [DATA_W-1:0] val1_s;
    logic [DATA_W-1:0] val2_s;

    assign ready_s = rst & (count_r != CNT_FULL);
    assign pop_s   = rst & (count_r != CNT_ZERO) & ~wb_hold;
    assign push_s  = ex.ex_valid & ready_s & ex.ex_wen;

    assign ex.ex_ready = ready_s;
    assign rf_we       = pop_s;
    assign rf_dst_idx  = dst_mem_r[head_r];
    assign rf_w_val    = val_mem_r[head_r];
    assign count       = count_r;

    for (genvar k = 0; k < DEPTH; k++) begin : g_age
        assign age_slot_s[k]  = head_r + PTR_W'(k);
        assign age_valid_s[k] = (CNT_W'(k) < count_r);
    end

    // Busy bits and bypass: scan oldest to youngest so the last match wins.
    always_comb begin
        busy_s = {BUSY_W{1'b0}};
        hit1_s = 1'b0;
        hit2_s = 1'b0;
        val1_s = {DATA_W{1'b0}};
        val2_s = {DATA_W{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            busy_s = busy_s
                   | ({BUSY_W{age_valid_s[k]}} & (BUSY_ONE << dst_mem_r[age_slot_s[k]]));
            hit1_s = hit1_s | (age_valid_s[k] & (dst_mem_r[age_slot_s[k]] == byp_idx1));
            hit2_s = hit2_s | (age_valid_s[k] & (dst_mem_r[age_slot_s[k]] == byp_idx2));
            val1_s = (age_valid_s[k] && (dst_mem_r[age_slot_s[k]] == byp_idx1))
                   ? val_mem_r[age_slot_s[k]] : val1_s;
            val2_s = (age_valid_s[k] && (dst_mem_r[age_slot_s[k]] == byp_idx2))
                   ? val_mem_r[age_slot_s[k]] : val2_s;
        end
    end

    assign busy     = busy_s;
    assign byp_hit1 = hit1_s;
    assign byp_hit2 = hit2_s;
    assign byp_val1 = val1_s;
    assign byp_val2 = val2_s;

    // FIFO storage, pointers and occupancy; reset discards every queued write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= CNT_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                dst_mem_r[i] <= {IDX_W{1'b0}};
                val_mem_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                dst_mem_r[tail_r] <= ex.ex_dst_idx;
                val_mem_r[tail_r] <= ex.ex_val;
                tail_r            <= tail_r + PTR_ONE;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: queue-based reference model checked every
// cycle, plus hand-computed expectations at key points.
module tb_reg_writeback;
    localparam int DEPTH  = 2;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_hold;
    logic        rf_we;
    logic [2:0]  rf_dst_idx;
    logic [31:0] rf_w_val;
    logic [7:0]  busy;
    logic [2:0]  byp_idx1;
    logic [2:0]  byp_idx2;
    logic        byp_hit1;
    logic        byp_hit2;
    logic [31:0] byp_val1;
    logic [31:0] byp_val2;
    logic [1:0]  count;

    always #5 clk = ~clk;

    reg_writeback_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) ex_if ();

    reg_writeback #(.DEPTH(DEPTH), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .ex        (ex_if),
        .wb_hold   (wb_hold),
        .rf_we     (rf_we),
        .rf_dst_idx(rf_dst_idx),
        .rf_w_val  (rf_w_val),
        .busy      (busy),
        .byp_idx1  (byp_idx1),
        .byp_idx2  (byp_idx2),
        .byp_hit1  (byp_hit1),
        .byp_hit2  (byp_hit2),
        .byp_val1  (byp_val1),
        .byp_val2  (byp_val2),
        .count     (count)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue holds exactly the writes not yet retired.
    typedef struct {
        logic [2:0]  idx;
        logic [31:0] val;
    } ent_t;

    ent_t q[$];
    ent_t m_ent;
    bit   m_acc;

    always @(posedge clk) begin
        if (!rst) begin
            q.delete();
        end else begin
            m_acc = ex_if.ex_valid && (q.size() < DEPTH) && ex_if.ex_wen;
            if (q.size() != 0 && !wb_hold) void'(q.pop_front());
            if (m_acc) begin
                m_ent.idx = ex_if.ex_dst_idx;
                m_ent.val = ex_if.ex_val;
                q.push_back(m_ent);
            end
        end
    end

    logic        e_ready, e_we, e_h1, e_h2;
    logic [7:0]  e_busy;
    logic [31:0] e_v1, e_v2;

    always @(negedge clk) begin
        if (cmp_en) begin
            e_ready = rst && (q.size() < DEPTH);
            e_we    = rst && (q.size() != 0) && !wb_hold;
            e_busy  = 8'h00;
            e_h1 = 1'b0; e_h2 = 1'b0; e_v1 = 32'h0; e_v2 = 32'h0;
            foreach (q[k]) begin
                e_busy[q[k].idx] = 1'b1;
                if (q[k].idx == byp_idx1) begin e_h1 = 1'b1; e_v1 = q[k].val; end
                if (q[k].idx == byp_idx2) begin e_h2 = 1'b1; e_v2 = q[k].val; end
            end
            check("m_ready", {31'h0, ex_if.ex_ready}, {31'h0, e_ready});
            check("m_we",    {31'h0, rf_we},          {31'h0, e_we});
            check("m_count", {30'h0, count},          q.size());
            check("m_busy",  {24'h0, busy},           {24'h0, e_busy});
            check("m_hit1",  {31'h0, byp_hit1},       {31'h0, e_h1});
            check("m_hit2",  {31'h0, byp_hit2},       {31'h0, e_h2});
            check("m_val1",  byp_val1,                e_v1);
            check("m_val2",  byp_val2,                e_v2);
            if (e_we) begin
                check("m_dst", {29'h0, rf_dst_idx}, {29'h0, q[0].idx});
                check("m_wval", rf_w_val, q[0].val);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [2:0] idx, input logic [31:0] val);
        ex_if.ex_valid   = v;
        ex_if.ex_wen     = w;
        ex_if.ex_dst_idx = idx;
        ex_if.ex_val     = val;
    endtask

    logic        s_v    [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        s_w    [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0]  s_idx  [8] = '{3'd6, 3'd7, 3'd6, 3'd6, 3'd2, 3'd1, 3'd1, 3'd0};
    logic        s_hold [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        rst = 1'b0; wb_hold = 1'b0; byp_idx1 = 3'd0; byp_idx2 = 3'd0;
        drive(1'b1, 1'b1, 3'd5, 32'h55);
        cyc();
        cmp_en = 1'b1;
        // Reset held with ex_valid asserted
        repeat (2) begin
            @(negedge clk);
            check("rst_ready", {31'h0, ex_if.ex_ready}, 32'h0);
            check("rst_we",    {31'h0, rf_we},          32'h0);
            check("rst_count", {30'h0, count},          32'h0);
            cyc();
        end
        rst = 1'b1;
        drive(1'b0, 1'b1, 3'd0, 32'h0);
        @(negedge clk);
        check("rel_ready", {31'h0, ex_if.ex_ready}, 32'h1);
        check("rel_busy",  {24'h0, busy},           32'h0);
        check("rel_dst",   {29'h0, rf_dst_idx},     32'h0);
        check("rel_wval",  rf_w_val,                32'h0);
        check("rel_hit1",  {31'h0, byp_hit1},       32'h0);

        // Single write
        cyc(); drive(1'b1, 1'b1, 3'd1, 32'hDEADBEEF); byp_idx1 = 3'd1; byp_idx2 = 3'd2;
        @(negedge clk);
        check("sw_hit_early", {31'h0, byp_hit1}, 32'h0);
        cyc(); drive(1'b0, 1'b1, 3'd0, 32'h0);
        @(negedge clk);
        check("sw_we",   {31'h0, rf_we},      32'h1);
        check("sw_dst",  {29'h0, rf_dst_idx}, 32'h1);
        check("sw_wval", rf_w_val,            32'hDEADBEEF);
        check("sw_busy", {24'h0, busy},       32'h02);
        check("sw_hit1", {31'h0, byp_hit1},   32'h1);
        check("sw_val1", byp_val1,            32'hDEADBEEF);
        cyc();
        @(negedge clk);
        check("sw_busy_after",  {24'h0, busy},  32'h0);
        check("sw_count_after", {30'h0, count}, 32'h0);

        // Fill under hold
        cyc(); wb_hold = 1'b1; drive(1'b1, 1'b1, 3'd0, 32'h11);
        cyc(); drive(1'b1, 1'b1, 3'd1, 32'h22);
        cyc(); drive(1'b0, 1'b1, 3'd0, 32'h0);
        @(negedge clk);
        check("fill_count", {30'h0, count},          32'h2);
        check("fill_ready", {31'h0, ex_if.ex_ready}, 32'h0);
        check("fill_we",    {31'h0, rf_we},          32'h0);
        check("fill_busy",  {24'h0, busy},           32'h03);
        cyc(); wb_hold = 1'b0;
        @(negedge clk);
        check("fill_w1",     rf_w_val,                32'h11);
        check("fill_ready1", {31'h0, ex_if.ex_ready}, 32'h0);
        cyc();
        @(negedge clk);
        check("fill_w2",     rf_w_val,                32'h22);
        check("fill_ready2", {31'h0, ex_if.ex_ready}, 32'h1);
        cyc();
        @(negedge clk);
        check("fill_drained", {31'h0, rf_we}, 32'h0);

        // Duplicate destination
        cyc(); wb_hold = 1'b1; byp_idx1 = 3'd0; drive(1'b1, 1'b1, 3'd0, 32'hA);
        cyc(); drive(1'b1, 1'b1, 3'd0, 32'hB);
        cyc(); drive(1'b0, 1'b1, 3'd0, 32'h0);
        @(negedge clk);
        check("dup_val1", byp_val1,          32'hB);
        check("dup_busy", {24'h0, busy},     32'h01);
        cyc(); wb_hold = 1'b0;
        @(negedge clk);
        check("dup_w1", rf_w_val, 32'hA);
        cyc();
        @(negedge clk);
        check("dup_w2", rf_w_val, 32'hB);
        cyc();

        // Discard with one entry already queued
        wb_hold = 1'b1; drive(1'b1, 1'b1, 3'd3, 32'h33);
        cyc(); drive(1'b1, 1'b0, 3'd2, 32'h77); byp_idx2 = 3'd2;
        @(negedge clk);
        check("dis_ready", {31'h0, ex_if.ex_ready}, 32'h1);
        cyc(); drive(1'b0, 1'b1, 3'd0, 32'h0);
        @(negedge clk);
        check("dis_count", {30'h0, count},    32'h1);
        check("dis_busy",  {24'h0, busy},     32'h08);
        check("dis_hit2",  {31'h0, byp_hit2}, 32'h0);
        cyc(); wb_hold = 1'b0;
        @(negedge clk);
        check("dis_dst", {29'h0, rf_dst_idx}, 32'h3);
        cyc();

        // Mid-operation reset with two queued entries
        wb_hold = 1'b1; drive(1'b1, 1'b1, 3'd4, 32'h44);
        cyc(); drive(1'b1, 1'b1, 3'd5, 32'h55);
        cyc(); drive(1'b0, 1'b1, 3'd0, 32'h0);
        @(negedge clk);
        check("mr_count", {30'h0, count}, 32'h2);
        check("mr_busy",  {24'h0, busy},  32'h30);
        cyc(); rst = 1'b0;
        @(negedge clk);
        check("mr_ready_low", {31'h0, ex_if.ex_ready}, 32'h0);
        check("mr_we_low",    {31'h0, rf_we},          32'h0);
        cyc(); rst = 1'b1; wb_hold = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("mr_count0", {30'h0, count}, 32'h0);
            check("mr_no_we",  {31'h0, rf_we}, 32'h0);
            cyc();
        end

        // Streaming with holds, discards and simultaneous push/pop
        for (int i = 0; i < 8; i++) begin
            drive(s_v[i], s_w[i], s_idx[i], 32'h1000 + i);
            wb_hold  = s_hold[i];
            byp_idx1 = 3'(i);
            byp_idx2 = 3'(7 - i);
            cyc();
        end
        drive(1'b0, 1'b1, 3'd0, 32'h0);
        wb_hold = 1'b0;
        repeat (4) cyc();
        @(negedge clk);
        check("end_count", {30'h0, count}, 32'h0);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_writeback.md
# reg_writeback

Writeback buffer that drives the register file's write port (`we`, `dst_idx`, `w_val`) from execute-stage results. It accepts results over a valid/ready handshake and queues them in a small in-order FIFO. It retires at most one queued write per cycle. While a result is queued, it publishes per-register pending-write (busy) bits and bypass values so the register-read stage can detect and resolve RAW hazards.

## Interface
Parameters:
- DEPTH, 2, FIFO entries (power of two, 2..4)
- DATA_W, 32, result width
- IDX_W, 3, register index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- ex_valid  in  1  execute result valid
- ex_ready  out  1  buffer can accept this cycle
- ex_wen  in  1  result writes a register (0 = accept and discard)
- ex_dst_idx  in  IDX_W  destination register index
- ex_val  in  DATA_W  result value
- wb_hold  in  1  freeze retirement (no rf write, no pop)
- rf_we  out  1  register file write enable
- rf_dst_idx  out  IDX_W  register file write index
- rf_w_val  out  DATA_W  register file write data
- busy  out  2^IDX_W  bit i = a queued entry targets register i
- byp_idx1, byp_idx2  in  IDX_W  read-stage source indices
- byp_hit1, byp_hit2  out  1  matching queued entry exists
- byp_val1, byp_val2  out  DATA_W  value from youngest matching entry (0 if no hit)
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Storage: DEPTH entries of {dst_idx, val}, plus head pointer, tail pointer and count; strict in-order FIFO.
- Accept: handshake occurs when ex_valid & ex_ready. ex_ready = rst & (count != DEPTH), combinational from registered count; there is no same-cycle pass-through when full.
- Accepted with ex_wen=1: enqueue at tail. Accepted with ex_wen=0: handshake completes, nothing is enqueued, count is unchanged.
- Retire: rf_we = (count != 0) & !wb_hold & rst. rf_dst_idx and rf_w_val come from the head entry. Head pops on the same edge the register file captures the write.
- Simultaneous enqueue and pop: count is unchanged and both pointers advance.
- wb_hold: rf_we=0, no pop; enqueue is still permitted up to full.
- busy[i]: OR over valid entries of (dst_idx == i), combinational from state. The head entry stays busy through its retiring cycle.
- Bypass: for each port, compare against all valid entries. hit = any match; val = youngest match (nearest tail). Duplicate destinations are written to the register file in order, oldest first.
- Pointers wrap modulo DEPTH.
- Reset (rst=0 at an edge):
  - count, head and tail go to 0; entry storage clears to 0; queued writes are discarded and never issued.
  - While rst=0, ex_ready=0 and rf_we=0.
  - After release: ex_ready=1, rf_we=0, rf_dst_idx=0, rf_w_val=0, busy=0, byp_hit*=0, byp_val*=0, count=0.

## Timing
- Single clock domain; no outputs registered beyond FIFO state.
- Minimum latency: result accepted at edge t → rf_we=1 during cycle t..t+1 → register file updated at edge t+1.
- Throughput: one accept and one retire per cycle sustained, with no bubbles when not full and not held.
- Bypass and busy reflect state after edge t for the whole following cycle. A result accepted at edge t is visible to bypass starting in cycle t+1, not in cycle t.
- When full, ex_ready drops in the cycle after the filling accept, and rises in the cycle after a pop.

## Test plan
- Reset: drive rst=0 for 2 cycles with ex_valid=1. Required: ex_ready=0, rf_we=0, count=0 throughout. After release: ex_ready=1, busy=0.
- Single write: accept {idx 1, 0xDEADBEEF}. Next cycle required: rf_we=1, rf_dst_idx=1, rf_w_val=0xDEADBEEF, busy=0x02, byp_hit1=1 for byp_idx1=1. Cycle after: busy=0, count=0.
- Fill under hold: wb_hold=1, accept idx0=0x11 and idx1=0x22. Required: count=2, ex_ready=0, rf_we=0. Release hold: writes 0x11 then 0x22 on consecutive cycles, and ex_ready returns to 1 after the first pop.
- Duplicate destination: wb_hold=1, accept idx0=0xA then idx0=0xB. Required: byp_val1=0xB for byp_idx1=0. Release: rf writes 0xA then 0xB, in that order.
- Discard: accept with ex_wen=0, idx 2. Required: handshake completes, count unchanged, busy[2]=0, no rf_we.
- Mid-operation reset: with 2 entries queued and wb_hold=1, pulse rst=0 for one cycle, then release hold. Required: count=0, rf_we never asserts for the discarded entries.
